// File: rtl/mem_arbiter_rr.sv
// mem_arbiter_rr
//   Round-robin arbiter that lets NUM_CORES requesters share one memory port.
//   Only one transaction is outstanding at a time. It passes through IDLE,
//   ISSUE, WAIT and RESP.
//
// Ports
//   clk, rst_n          : clock, asynchronous active-low reset
//   core_req/we         : per-core request and direction (1 = write)
//   core_addr/wdata     : per-core address and write data, core i in slice i
//   core_funct3         : per-core size/sign code, core i in slice i
//   core_gnt            : one-hot grant pulse, issued in IDLE
//   core_done           : one-hot completion pulse, issued in RESP
//   core_rdata          : read data captured on entry to RESP
//   mem_addr/wdata/funct3, mem_read/mem_write : request to memory
//   mem_ready, mem_rvalid, mem_rdata           : memory handshake and response
//   busy, owner_id      : not-IDLE flag, index of the core being served
module mem_arbiter_rr #(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = $clog2(NUM_CORES)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CORES-1:0]        core_req,
  input  logic [NUM_CORES-1:0]        core_we,
  input  logic [NUM_CORES*ADDR_W-1:0] core_addr,
  input  logic [NUM_CORES*DATA_W-1:0] core_wdata,
  input  logic [NUM_CORES*3-1:0]      core_funct3,
  output logic [NUM_CORES-1:0]        core_gnt,
  output logic [NUM_CORES-1:0]        core_done,
  output logic [DATA_W-1:0]           core_rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  output logic [2:0]                  mem_funct3,
  output logic                        mem_read,
  output logic                        mem_write,
  input  logic                        mem_ready,
  input  logic                        mem_rvalid,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy,
  output logic [ID_W-1:0]             owner_id
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ID_W-1:0]     r_last_ptr;
  logic [ID_W-1:0]     r_owner;
  logic                r_we;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;
  logic [2:0]          r_funct3;
  logic [DATA_W-1:0]   r_rdata;

  logic                w_any;
  logic                w_hi_found;
  logic                w_lo_found;
  logic [ID_W-1:0]     w_hi;
  logic [ID_W-1:0]     w_lo;
  logic [ID_W-1:0]     w_win;
  logic                w_sel_we;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_wdata;
  logic [2:0]          w_sel_funct3;

  assign w_any = |core_req;

  // Round-robin search from last_ptr+1 with wrap-around: the lowest requester
  // above last_ptr wins. If there is none, the lowest requester overall wins.
  always_comb begin
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    w_hi       = '0;
    w_lo       = '0;
    for (int unsigned j = 0; j < NUM_CORES; j++) begin
      if (core_req[j]) begin
        if (!w_hi_found && (ID_W'(j) > r_last_ptr)) begin
          w_hi_found = 1'b1;
          w_hi       = ID_W'(j);
        end
        if (!w_lo_found) begin
          w_lo_found = 1'b1;
          w_lo       = ID_W'(j);
        end
      end
    end
    w_win = w_hi_found ? w_hi : w_lo;
  end

  // Grant decode and request-field mux for the winner.
  always_comb begin
    core_gnt     = '0;
    w_sel_we     = 1'b0;
    w_sel_addr   = '0;
    w_sel_wdata  = '0;
    w_sel_funct3 = '0;
    for (int unsigned j = 0; j < NUM_CORES; j++) begin
      if (ID_W'(j) == w_win) begin
        core_gnt[j]  = (r_state == S_IDLE) && w_any;
        w_sel_we     = core_we[j];
        w_sel_addr   = core_addr[j*ADDR_W +: ADDR_W];
        w_sel_wdata  = core_wdata[j*DATA_W +: DATA_W];
        w_sel_funct3 = core_funct3[j*3 +: 3];
      end
    end
  end

  always_comb begin
    core_done = '0;
    for (int unsigned j = 0; j < NUM_CORES; j++) begin
      core_done[j] = (r_state == S_RESP) && (ID_W'(j) == r_owner);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_next = S_ISSUE;
      S_ISSUE: if (mem_ready) w_next = mem_rvalid ? S_RESP : S_WAIT;
      S_WAIT:  if (mem_rvalid) w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // The captured request fields are cleared when the transaction finishes.
  // This keeps the memory bus at zero while the arbiter is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_ptr <= ID_W'(NUM_CORES - 1);
      r_owner    <= '0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_funct3   <= '0;
      r_rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_owner  <= w_win;
            r_we     <= w_sel_we;
            r_addr   <= w_sel_addr;
            r_wdata  <= w_sel_wdata;
            r_funct3 <= w_sel_funct3;
          end
        end
        S_ISSUE, S_WAIT: begin
          if (w_next == S_RESP) r_rdata <= mem_rdata;
        end
        S_RESP: begin
          r_last_ptr <= r_owner;
          r_we       <= 1'b0;
          r_addr     <= '0;
          r_wdata    <= '0;
          r_funct3   <= '0;
        end
        default: ;
      endcase
    end
  end

  assign mem_read   = (r_state == S_ISSUE) && !r_we;
  assign mem_write  = (r_state == S_ISSUE) && r_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign mem_funct3 = r_funct3;
  assign core_rdata = r_rdata;
  assign busy       = (r_state != S_IDLE);
  assign owner_id   = r_owner;

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb_mem_arbiter_rr
//   Directed bench for mem_arbiter_rr with NUM_CORES=4.
//   Inputs change on the falling clock edge. Outputs are checked 1 time unit later.
module tb_mem_arbiter_rr;

  localparam int unsigned NC = 4;

  logic           clk;
  logic           rst_n;
  logic [NC-1:0]  core_req;
  logic [NC-1:0]  core_we;
  logic [NC*32-1:0] core_addr;
  logic [NC*32-1:0] core_wdata;
  logic [NC*3-1:0]  core_funct3;
  logic [NC-1:0]  core_gnt;
  logic [NC-1:0]  core_done;
  logic [31:0]    core_rdata;
  logic [31:0]    mem_addr;
  logic [31:0]    mem_wdata;
  logic [2:0]     mem_funct3;
  logic           mem_read;
  logic           mem_write;
  logic           mem_ready;
  logic           mem_rvalid;
  logic [31:0]    mem_rdata;
  logic           busy;
  logic [1:0]     owner_id;

  int n_assert;
  int n_fail;

  mem_arbiter_rr #(.NUM_CORES(NC), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_funct3(core_funct3),
    .core_gnt(core_gnt), .core_done(core_done), .core_rdata(core_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_funct3(mem_funct3),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .busy(busy), .owner_id(owner_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Move to the next falling edge. Callers then drive inputs and wait #1 before checking.
  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_assert = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0; core_funct3 = '0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

    // Reset state
    nxt(); nxt(); #1;
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_owner", 64'(owner_id), 64'd0);
    chk("rst_rdata", 64'(core_rdata), 64'd0);
    chk("rst_strb",  64'({mem_read, mem_write}), 64'd0);
    chk("rst_done",  64'(core_done), 64'd0);
    chk("rst_addr",  64'(mem_addr), 64'd0);
    nxt(); rst_n = 1'b1;

    // Single read from core 1 with minimum latency
    nxt();
    core_req = 4'b0010; core_addr[32 +: 32] = 32'h100;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("rd_gnt",  64'(core_gnt), 64'h2);
    chk("rd_busy0", 64'(busy), 64'd0);
    nxt(); core_req = '0; #1;
    chk("rd_read",  64'({mem_read, mem_write}), 64'h2);
    chk("rd_addr",  64'(mem_addr), 64'h100);
    chk("rd_owner", 64'(owner_id), 64'd1);
    chk("rd_busy1", 64'(busy), 64'd1);
    chk("rd_nogntbusy", 64'(core_gnt), 64'd0);
    nxt(); mem_ready = 1'b0; mem_rvalid = 1'b0; #1;
    chk("rd_done",  64'(core_done), 64'h2);
    chk("rd_rdata", 64'(core_rdata), 64'hDEADBEEF);
    chk("rd_strb_off", 64'({mem_read, mem_write}), 64'd0);
    nxt(); #1;
    chk("rd_done_off", 64'(core_done), 64'd0);
    chk("rd_idle", 64'(busy), 64'd0);
    chk("rd_idle_addr", 64'(mem_addr), 64'd0);
    chk("rd_hold", 64'(core_rdata), 64'hDEADBEEF);

    // Write from core 0 under 3 cycles of backpressure. Core 2 requests while busy.
    core_req = 4'b0001; core_we = 4'b0001;
    core_addr[0 +: 32] = 32'h40; core_wdata[0 +: 32] = 32'h12345678; core_funct3[0 +: 3] = 3'b010;
    #1;
    chk("wr_gnt", 64'(core_gnt), 64'h1);
    nxt(); core_req = 4'b0100; #1;
    chk("wr_strb", 64'({mem_read, mem_write}), 64'h1);
    chk("wr_addr", 64'(mem_addr), 64'h40);
    chk("wr_data", 64'(mem_wdata), 64'h12345678);
    chk("wr_f3",   64'(mem_funct3), 64'h2);
    chk("wr_nogntbusy", 64'(core_gnt), 64'd0);
    for (int c = 0; c < 2; c++) begin
      nxt(); #1;
      chk("bp_addr",  64'(mem_addr), 64'h40);
      chk("bp_write", 64'(mem_write), 64'd1);
      chk("bp_done",  64'(core_done), 64'd0);
    end
    nxt(); core_req = '0; mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hAAAA5555; #1;
    chk("bp_addr3",  64'(mem_addr), 64'h40);
    chk("bp_write3", 64'(mem_write), 64'd1);
    nxt(); mem_ready = 1'b0; mem_rvalid = 1'b0; #1;
    chk("wr_done", 64'(core_done), 64'h1);
    nxt(); #1;
    chk("wr_done_once", 64'(core_done), 64'd0);
    chk("wr_idle", 64'(busy), 64'd0);
    chk("drop_nogrant", 64'(core_gnt), 64'd0);
    core_we = '0;

    // Split completion on core 3. WAIT lasts 4 cycles.
    nxt(); core_req = 4'b1000; core_addr[96 +: 32] = 32'h300; #1;
    chk("sp_gnt", 64'(core_gnt), 64'h8);
    nxt(); core_req = '0; mem_ready = 1'b1; #1;
    chk("sp_read", 64'(mem_read), 64'd1);
    chk("sp_owner", 64'(owner_id), 64'd3);
    chk("sp_busy_t1", 64'(busy), 64'd1);
    for (int c = 0; c < 3; c++) begin
      nxt(); mem_ready = 1'b0; #1;
      chk("sp_wait_strb", 64'({mem_read, mem_write}), 64'd0);
      chk("sp_wait_busy", 64'(busy), 64'd1);
      chk("sp_wait_done", 64'(core_done), 64'd0);
    end
    nxt(); mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D; #1;
    chk("sp_t5_done", 64'(core_done), 64'd0);
    chk("sp_t5_busy", 64'(busy), 64'd1);
    nxt(); mem_rvalid = 1'b0; #1;
    chk("sp_done", 64'(core_done), 64'h8);
    chk("sp_rdata", 64'(core_rdata), 64'hCAFEF00D);
    chk("sp_t6_busy", 64'(busy), 64'd1);
    nxt(); #1;
    chk("sp_idle", 64'(busy), 64'd0);

    // All cores requesting continuously. The expected grant order is 0,1,2,3,0,1.
    core_req = 4'b1111; mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1111;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("rr_gnt", 64'(core_gnt), 64'(4'b0001 << (k % 4)));
      nxt(); #1;
      chk("rr_owner", 64'(owner_id), 64'(k % 4));
      nxt();
      if (k == 5) core_req = '0;
      #1;
      chk("rr_done", 64'(core_done), 64'(4'b0001 << (k % 4)));
      nxt();
    end
    #1;
    chk("rr_stop", 64'(core_gnt), 64'd0);

    // Reset asserted in WAIT. Afterwards core 0 must win over core 2.
    nxt(); core_req = 4'b0100; mem_ready = 1'b1; mem_rvalid = 1'b0; #1;
    chk("rw_gnt", 64'(core_gnt), 64'h4);
    nxt(); core_req = '0; #1;
    nxt(); mem_ready = 1'b0; #1;
    chk("rw_inwait", 64'(busy), 64'd1);
    #1; rst_n = 1'b0; mem_rvalid = 1'b1; #1;
    chk("rw_busy", 64'(busy), 64'd0);
    chk("rw_owner", 64'(owner_id), 64'd0);
    chk("rw_rdata", 64'(core_rdata), 64'd0);
    chk("rw_done", 64'(core_done), 64'd0);
    chk("rw_addr", 64'(mem_addr), 64'd0);
    nxt(); rst_n = 1'b1; mem_rvalid = 1'b0; #1;
    chk("rw_nodone", 64'(core_done), 64'd0);
    nxt(); core_req = 4'b0101; mem_ready = 1'b1; mem_rvalid = 1'b1; #1;
    chk("rw_prio", 64'(core_gnt), 64'h1);
    nxt(); core_req = '0; #1;
    nxt(); #1;
    chk("rw_done0", 64'(core_done), 64'h1);
    nxt();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter_rr.md
MEM_ARBITER_RR -- requirements
Module: mem_arbiter_rr

Interface
REQ-001 Parameter NUM_CORES, default 2: number of requesting cores; legal range 2-8.
REQ-002 Parameter ADDR_W, default 32: address width.
REQ-003 Parameter DATA_W, default 32: data width.
REQ-004 Parameter ID_W, default $clog2(NUM_CORES): width of the grant index.
REQ-005 clk  in  1  sole clock; all state updates on the rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 core_req  in  NUM_CORES  per-core access request; held high until granted.
REQ-008 core_we  in  NUM_CORES  per-core direction: 1 = write, 0 = read.
REQ-009 core_addr  in  NUM_CORES*ADDR_W  per-core address; core i occupies slice i.
REQ-010 core_wdata  in  NUM_CORES*DATA_W  per-core write data.
REQ-011 core_funct3  in  NUM_CORES*3  per-core access size/sign code.
REQ-012 core_gnt  out  NUM_CORES  one-hot, one-cycle pulse: request accepted and captured.
REQ-013 core_done  out  NUM_CORES  one-hot, one-cycle pulse: access complete.
REQ-014 core_rdata  out  DATA_W  read data; valid while core_done is high, held until the next completion.
REQ-015 mem_addr / mem_wdata / mem_funct3  out  ADDR_W / DATA_W / 3  captured request fields.
REQ-016 mem_read, mem_write  out  1 each  memory strobes, held until accepted.
REQ-017 mem_ready  in  1  memory accepts the strobed request this cycle.
REQ-018 mem_rvalid  in  1  memory completion: read data valid, or write done.
REQ-019 mem_rdata  in  DATA_W  memory read data.
REQ-020 busy  out  1  high in any state other than IDLE.
REQ-021 owner_id  out  ID_W  index of the core currently being served.

Function
REQ-022 FSM states: IDLE, ISSUE, WAIT, RESP; exactly one transaction is outstanding at a time.
REQ-023 IDLE with any core_req high: select winner w by round-robin, searching from (last_ptr+1) mod NUM_CORES upward with wrap-around.
REQ-024 In that same cycle: core_gnt[w]=1 combinationally; capture we/addr/wdata/funct3 of w and w into owner_id; go to ISSUE.
REQ-025 ISSUE: mem_read=~we_q and mem_write=we_q; all mem_* fields stable while mem_ready=0.
REQ-026 ISSUE and mem_ready=1 and mem_rvalid=0: go to WAIT.
REQ-027 ISSUE and mem_ready=1 and mem_rvalid=1: go directly to RESP.
REQ-028 WAIT: strobes low; mem_rvalid=1 -> go to RESP.
REQ-029 Entry to RESP (whether from ISSUE or WAIT): capture mem_rdata into core_rdata (writes also capture it, value unspecified to the core).
REQ-030 RESP: core_done[owner_id]=1 for one cycle; last_ptr<=owner_id; go to IDLE.
REQ-031 Minimum latency: gnt at cycle t, mem strobe at t+1, done at t+2 when mem_ready=mem_rvalid=1 at t+1.
REQ-032 core_req is ignored outside IDLE; no gnt is issued while busy=1.
REQ-033 Fairness: a continuously requesting core is granted within NUM_CORES transactions.
REQ-034 A request dropped before its grant is legal and produces no grant.
REQ-035 mem_rvalid outside ISSUE/WAIT is ignored; mem_ready outside ISSUE is ignored.
REQ-036 When idle, mem_addr, mem_wdata and mem_funct3 are 0 and both strobes are 0.

Reset
REQ-037 rst_n low, asynchronously: state=IDLE, last_ptr=NUM_CORES-1 (so core 0 wins first), owner_id=0, core_rdata=0, all gnt/done/strobes/busy=0.
REQ-038 Reset mid-transaction drops the transaction with no done pulse; the first grant after release follows REQ-037 priority.

Verification
REQ-039 Single read: core1 req, addr 0x100, mem_rdata 0xDEADBEEF with mem_ready=mem_rvalid=1 -> gnt[1] at t, mem_read at t+1, done[1] at t+2, core_rdata=0xDEADBEEF.
REQ-040 All cores requesting continuously with NUM_CORES=4 -> grant order 0,1,2,3,0,1.
REQ-041 Backpressure: mem_ready low for 3 cycles -> mem_addr and mem_write stable over those 3 cycles, exactly one done.
REQ-042 Split completion: mem_ready at t+1, mem_rvalid at t+5 -> WAIT for 4 cycles, done at t+6, busy high t+1..t+6.
REQ-043 rst_n pulsed low while in WAIT -> outputs reset immediately, no done; the next request from cores 0 and 2 grants core 0.
REQ-044 Write: core0 we=1, wdata 0x12345678 -> mem_write=1 and mem_wdata=0x12345678 on the bus, done[0] pulsed, core_rdata unchanged is not checked.
